uart_rx_oversample_voter: RTL

//  Parametrised next-generation UART RX data sampler. Takes N samples of RX_IN

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_oversample_voter_sync.sv | 22 ++
 rtl/uart_rx_oversample_voter.sv | 79 +++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and helpers for the oversampling UART receiver
//   MAX_SAMPLES  widest vote supported by the popcount helper
//   first_tick   first capture tick of a window centred on prescale>>1
//   popcount7    number of ones in a MAX_SAMPLES-wide vector
package uart_rx_pkg;

    localparam int MAX_SAMPLES = 7;

    function automatic logic [31:0] first_tick(input logic [31:0] prescale, input int n);
        return (prescale >> 1) - 32'((n - 1) / 2);
    endfunction

    function automatic logic [2:0] popcount7(input logic [MAX_SAMPLES-1:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < MAX_SAMPLES; i++) c = c + 3'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_oversample_voter_sync.sv
// uart_bit_sync: STAGES-deep synchroniser for the serial line, plain wire when STAGES=0
//   clk, reset  clock and synchronous active-high reset
//   d           asynchronous serial input
//   q           d delayed by STAGES clock cycles
module uart_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES == 0) begin : g_bypass
        assign q = d;
    end else begin : g_sync
        logic [STAGES-1:0] sr;
        always_ff @(posedge clk) sr <= reset ? '0 : STAGES'({sr, d});
        assign q = sr[STAGES-1];
    end

endmodule

// File: rtl/uart_rx_oversample_voter.sv
// uart_rx_oversample_voter: majority vote of NUM_SAMPLES samples centred on the bit midpoint
//   clk, reset    clock and synchronous active-high reset
//   RX_IN         serial line (synchronised internally when SYNC_STAGES>0)
//   prescale      oversampling ratio, edge_count = tick index inside the bit
//   sample_en     sampling window enable from the RX FSM
//   sample_bit    voted bit, held until the next sample_valid
//   sample_valid  one-cycle strobe marking a new vote
//   noise_err     last vote's samples were not unanimous
//   cfg_err       prescale too small to fit the window
module uart_rx_oversample_voter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_count,
    input  logic                  sample_en,
    output logic                  sample_bit,
    output logic                  sample_valid,
    output logic                  noise_err,
    output logic                  cfg_err
);

    localparam int W  = PRESCALE_W + 1;
    localparam int CW = $clog2(NUM_SAMPLES + 1);

    logic                   rx_s;
    logic [W-1:0]           pre, ec, first, last;
    logic [PRESCALE_W-1:0]  prev_ec;
    logic [NUM_SAMPLES-1:0] samples, next_samples;
    logic [CW-1:0]          count;
    logic [2:0]             ones;
    logic                   cfg_bad, in_win, cap, done;

    uart_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .reset(reset), .d(RX_IN), .q(rx_s));

    // one extra bit keeps the window end from wrapping at the largest prescale
    assign pre          = W'(prescale);
    assign ec           = W'(edge_count);
    assign first        = W'(first_tick(32'(prescale), NUM_SAMPLES));
    assign last         = first + W'(NUM_SAMPLES - 1);
    assign cfg_bad      = pre < W'(NUM_SAMPLES + 2);
    assign in_win       = ec >= first && ec <= last;
    // a tick held for several cycles only captures on the cycle it changes
    assign cap          = sample_en && !cfg_bad && !cfg_err && in_win && edge_count != prev_ec;
    assign next_samples = NUM_SAMPLES'({samples, rx_s});
    assign done         = cap && ec != first && count == CW'(NUM_SAMPLES - 1);
    assign ones         = popcount7(MAX_SAMPLES'(next_samples));

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ec      <= '0;
            samples      <= '0;
            count        <= '0;
            cfg_err      <= 1'b0;
            sample_valid <= 1'b0;
            sample_bit   <= 1'b0;
            noise_err    <= 1'b0;
        end else begin
            prev_ec      <= edge_count;
            cfg_err      <= cfg_bad;
            sample_valid <= done;
            if (cap) samples <= next_samples;
            // the first tick restarts the window so a stale partial count never carries over
            if (!sample_en || cfg_bad) count <= '0;
            else if (cap) count <= ec == first ? CW'(1) : count + CW'(1);
            if (done) begin
                sample_bit <= ones > 3'(NUM_SAMPLES / 2);
                noise_err  <= ones != 3'd0 && ones != 3'(NUM_SAMPLES);
            end
        end
    end

endmodule
